instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming RISC-V instruction encoder and program writer: accepts decoded instruction fields (class, registers, funct, immediate) over a valid/ready handshake, packs them into 32-bit RV32I words, and writes them to consecutive instruction-memory word addresses. It is the producer-side counterpart of the main control decoder: it emits exactly the opcodes that decoder recognises (LOAD, STORE, R-type, I-type ALU, BRANCH). It sits between the test/boot loader and the instruction memory write port.

## Interface
- ADDR_W, 8, instruction-memory word-address width
- BASE_ADDR, 0, first word address written after reset or `start`
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  restart: address <- BASE_ADDR, count <- 0, clear `err` and `full`
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder accepts bundle this cycle
- in_class  in  3  0 LOAD, 1 STORE, 2 RTYPE, 3 ITYPE, 4 BRANCH, 5-7 illegal
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3 ; in_funct7  in  7 (RTYPE only)
- in_imm  in  32  signed immediate; branch = byte offset
- mem_we  out  1  write request (word pending)
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  memory accepts write this cycle
- count  out  ADDR_W+1  words written since reset/start
- full  out  1  last address written; no further acceptance
- err  out  1  sticky: at least one bundle dropped

## Operation
- Opcodes: LOAD 0000011, STORE 0100011, RTYPE 0110011, ITYPE 0010011, BRANCH 1100011.
- Packing: R = f7|rs2|rs1|f3|rd|op; I (LOAD/ITYPE) = imm[11:0]|rs1|f3|rd|op; S = imm[11:5]|rs2|rs1|f3|imm[4:0]|op; B = imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
- Unused fields are ignored (e.g. in_rd on STORE, in_funct7 on non-RTYPE).
- FSM:
  - EMPTY: in_ready=1; a legal accepted bundle -> PEND.
  - PEND: mem_we=1. On mem_ready: address+1 and count+1. Then:
    - if the address just written was 2^ADDR_W-1 -> DONE;
    - else if a new legal bundle is accepted in the same cycle -> stay PEND;
    - else -> EMPTY.
  - DONE: full=1, in_ready=0, until `start`.
- in_ready = !full & !start & (state==EMPTY | (PEND & mem_ready & not last address)).
- Illegal class: bundle is consumed (handshake completes), nothing written, err<-1, state unchanged.
- start: honoured only when mem_we=0; ignored while PEND (the pending write completes first). When honoured, in_ready=0 that cycle and the state goes to EMPTY.
- Address wraps only through `start`; it never silently rolls over.

## Timing
- Reset values: mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err=0, in_ready=1 after release; state EMPTY.
- Latency: bundle accepted at edge N -> mem_we/mem_wdata valid after edge N, held stable until mem_ready.
- Throughput: 1 word/cycle with mem_ready held high.
- Reset mid-write drops the pending word; no partial state survives.

## Configuration
- ENC_IMM_CHECK_EN defined: I/S immediates must fit signed 12 bits; B must fit signed 13 bits with bit0=0. A violating bundle is consumed, dropped, and sets err.
- ENC_IMM_CHECK_EN undefined: the immediate is truncated silently, branch bit0 is ignored, and no error is raised for range.

## Structure
- Package enc_pkg: class codes, the five opcode constants, and the state enum.
- Sub-module instr_pack: combinational class+fields -> {word, legal, imm_ok}. The top holds the FSM, output register, address and count.

## Test plan
- ITYPE rd=1 rs1=0 f3=0 imm=5, mem_ready=1 -> mem_wdata=0x00500093 at addr 0 one cycle later; count=1.
- RTYPE rd=3 rs1=1 rs2=2 f3=0 f7=0, then STORE rs1=1 rs2=2 f3=2 imm=8 back-to-back -> 0x002081B3 at addr 0, 0x0020A423 at addr 1, no bubbles.
- BRANCH rs1=1 rs2=2 f3=0 imm=-4 with mem_ready low 3 cycles -> word 0xFE208EE3 held stable, in_ready=0 until accepted.
- in_class=6 -> no mem_we, err=1, address unchanged; `start` clears err.
- ADDR_W=2: 4 writes -> full=1, in_ready=0, count=4; `start` -> addr 0, count 0.
- With ENC_IMM_CHECK_EN, ITYPE imm=2048 -> dropped, err=1; without the macro -> word 0x80000093 (truncated imm), err=0.

Source files
------------

// File: rtl/enc_pkg.sv
// enc_pkg: shared definitions for the instruction encoder.
//   - field-bundle class codes as presented on in_class
//   - the five RV32I opcodes the encoder can emit
//   - encoder FSM state enum
package enc_pkg;

  localparam logic [2:0] CLS_LOAD   = 3'd0;
  localparam logic [2:0] CLS_STORE  = 3'd1;
  localparam logic [2:0] CLS_RTYPE  = 3'd2;
  localparam logic [2:0] CLS_ITYPE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PEND,
    ST_DONE
  } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational packer, decoded fields -> 32-bit RV32I word.
// Ports:
//   cls_i      bundle class (0..4 legal, 5..7 illegal)
//   rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i   instruction fields
//   word_o     packed instruction (0 for illegal classes)
//   legal_o    class is one of the five supported formats
//   imm_ok_o   immediate fits its format (always 1 unless ENC_IMM_CHECK_EN)
// Config macro: ENC_IMM_CHECK_EN enables immediate range checking.
module instr_pack
  import enc_pkg::*;
(
  input  logic [2:0]  cls_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        legal_o,
  output logic        imm_ok_o
);

`ifdef ENC_IMM_CHECK_EN
  // Signed-fit test: every bit above the sign position matches the sign.
  logic fits12;
  logic fits13;
  assign fits12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign fits13 = ((&imm_i[31:12]) | ~(|imm_i[31:12])) & ~imm_i[0];
`else
  logic unused_imm;
  assign unused_imm = ^{imm_i[31:13], imm_i[0]};
`endif

  always_comb begin
    word_o   = '0;
    legal_o  = 1'b1;
    imm_ok_o = 1'b1;
    unique case (cls_i)
      CLS_LOAD:   word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
      CLS_ITYPE:  word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_ITYPE};
      CLS_STORE:  word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
      CLS_RTYPE:  word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_RTYPE};
      CLS_BRANCH: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], OP_BRANCH};
      default:    legal_o = 1'b0;
    endcase
`ifdef ENC_IMM_CHECK_EN
    unique case (cls_i)
      CLS_LOAD, CLS_ITYPE, CLS_STORE: imm_ok_o = fits12;
      CLS_BRANCH:                     imm_ok_o = fits13;
      default:                        imm_ok_o = 1'b1;
    endcase
`endif
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I encoder and instruction-memory writer.
// Accepts field bundles on a valid/ready handshake, packs them (instr_pack)
// and writes them to consecutive word addresses starting at BASE_ADDR.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               restart address/count, clear err/full (idle only)
//   in_valid/in_ready   bundle handshake
//   in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm   fields
//   mem_we/mem_ready    write request handshake
//   mem_addr, mem_wdata write address and encoded word
//   count               words written since reset/start
//   full                last address written, acceptance stopped
//   err                 sticky: a bundle was dropped
// Config macro: ENC_IMM_CHECK_EN drops bundles whose immediate does not fit.
module instr_encoder
  import enc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;

  logic [31:0] pack_word;
  logic        pack_legal;
  logic        pack_imm_ok;

  instr_pack u_pack (
    .cls_i    (in_class),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .funct3_i (in_funct3),
    .funct7_i (in_funct7),
    .imm_i    (in_imm),
    .word_o   (pack_word),
    .legal_o  (pack_legal),
    .imm_ok_o (pack_imm_ok)
  );

  logic last_addr, accept, take, drop, write_done, start_ok;

  assign last_addr  = (addr_q == '1);
  assign accept     = in_valid & in_ready;
  assign take       = accept & pack_legal & pack_imm_ok;
  assign drop       = accept & ~(pack_legal & pack_imm_ok);
  assign write_done = mem_we & mem_ready;
  // A pending write always completes before a restart is honoured.
  assign start_ok   = start & (state_q != ST_PEND);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (start_ok)  state_d = ST_EMPTY;
        else if (take) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (mem_ready) begin
          if (last_addr) state_d = ST_DONE;
          else if (take) state_d = ST_PEND;
          else           state_d = ST_EMPTY;
        end
      end
      ST_DONE: begin
        if (start_ok) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    mem_we   = (state_q == ST_PEND);
    full     = (state_q == ST_DONE);
    in_ready = ~full & ~start &
               ((state_q == ST_EMPTY) | ((state_q == ST_PEND) & mem_ready & ~last_addr));
  end

  // Datapath next values; the address holds at the top rather than wrapping.
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (start_ok) begin
      addr_d  = BASE;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (write_done) begin
        count_d = count_q + (ADDR_W+1)'(1);
        if (!last_addr) addr_d = addr_q + ADDR_W'(1);
      end
      if (drop) err_d = 1'b1;
    end
    if (take) wdata_d = pack_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= BASE;
      count_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_class = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [31:0]   in_imm = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready = 1'b0;
  logic [AW:0]   count;
  logic          full;
  logic          err;

  int vectors = 0;
  int miscompares = 0;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  // Reference encoder: fields placed by shifting and masking per format.
  function automatic logic [31:0] ref_word(input int cls, input logic [31:0] rd,
      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] f3,
      input logic [31:0] f7, input logic [31:0] imm);
    logic [31:0] op;
    logic [31:0] base;
    case (cls)
      0:       op = 32'h03;
      1:       op = 32'h23;
      2:       op = 32'h33;
      3:       op = 32'h13;
      default: op = 32'h63;
    endcase
    base = (rs1 << 15) | (f3 << 12) | op;
    case (cls)
      0, 3:    return base | ((imm & 32'hFFF) << 20) | (rd << 7);
      1:       return base | (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | ((imm & 32'h1F) << 7);
      2:       return base | (f7 << 25) | (rs2 << 20) | (rd << 7);
      default: return base | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                      | (rs2 << 20) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
    endcase
  endfunction

  function automatic bit ref_legal(input int cls, input logic [31:0] imm);
    bit ok;
    int s;
    ok = (cls <= 4);
    s  = int'(imm);
`ifdef ENC_IMM_CHECK_EN
    if (ok && cls != 2) begin
      if (cls == 4) ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
      else          ok = (s >= -2048) && (s <= 2047);
    end
`else
    if (s == 0) ok = ok;
`endif
    return ok;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input int cls, input int rd, input int rs1, input int rs2,
                            input int f3, input int f7, input logic [31:0] imm);
    in_class  = 3'(cls);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_funct3 = 3'(f3);
    in_funct7 = 7'(f7);
    in_imm    = imm;
    in_valid  = 1'b1;
  endtask

  task automatic do_start();
    in_valid = 1'b0;
    start = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL start_ready got %b exp 0", in_ready);
    end
    tick();
    start = 1'b0;
    vectors++;
    if (mem_addr !== '0 || count !== '0 || err !== 1'b0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL start_clear got addr=%0d count=%0d err=%b full=%b exp 0/0/0/0",
               mem_addr, count, err, full);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mem got we=%b addr=%0d wdata=%h exp 0/0/0", mem_we, mem_addr, mem_wdata);
    end
    vectors++;
    if (count !== '0 || full !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_status got count=%0d full=%b err=%b ready=%b exp 0/0/0/1",
               count, full, err, in_ready);
    end
  endtask

  task automatic test_itype();
    mem_ready = 1'b1;
    set_bundle(3, 1, 0, 0, 0, 0, 32'd5);
    tick();
    in_valid = 1'b0;
    vectors++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'h00500093 || mem_addr !== 2'd0) begin
      miscompares++;
      $display("FAIL itype_word got we=%b data=%h addr=%0d exp 1/00500093/0", mem_we, mem_wdata, mem_addr);
    end
    tick();
    vectors++;
    if (count !== 3'd1 || mem_we !== 1'b0 || mem_addr !== 2'd1) begin
      miscompares++;
      $display("FAIL itype_after got count=%0d we=%b addr=%0d exp 1/0/1", count, mem_we, mem_addr);
    end
  endtask

  task automatic test_back_to_back();
    do_start();
    mem_ready = 1'b1;
    set_bundle(2, 3, 1, 2, 0, 0, 32'h0);
    tick();
    set_bundle(1, 0, 1, 2, 2, 0, 32'd8);
    #1;
    vectors++;
    if (in_ready !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h002081B3 || mem_addr !== 2'd0) begin
      miscompares++;
      $display("FAIL b2b_first got ready=%b we=%b data=%h addr=%0d exp 1/1/002081b3/0",
               in_ready, mem_we, mem_wdata, mem_addr);
    end
    tick();
    in_valid = 1'b0;
    vectors++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'h0020A423 || mem_addr !== 2'd1) begin
      miscompares++;
      $display("FAIL b2b_second got we=%b data=%h addr=%0d exp 1/0020a423/1", mem_we, mem_wdata, mem_addr);
    end
    tick();
    vectors++;
    if (mem_we !== 1'b0 || count !== 3'd2) begin
      miscompares++;
      $display("FAIL b2b_done got we=%b count=%0d exp 0/2", mem_we, count);
    end
  endtask

  task automatic test_stall();
    do_start();
    mem_ready = 1'b0;
    set_bundle(4, 0, 1, 2, 0, 0, -32'sd4);
    tick();
    set_bundle(3, 5, 6, 0, 0, 0, 32'd1);
    start = 1'b1;  // must be ignored while the write is pending
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (mem_we !== 1'b1 || mem_wdata !== 32'hFE208EE3 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold got we=%b data=%h ready=%b exp 1/fe208ee3/0", mem_we, mem_wdata, in_ready);
      end
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
    mem_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || mem_addr !== 2'd0) begin
      miscompares++;
      $display("FAIL stall_release got ready=%b addr=%0d exp 1/0", in_ready, mem_addr);
    end
    tick();
    vectors++;
    if (mem_we !== 1'b0 || count !== 3'd1 || mem_addr !== 2'd1) begin
      miscompares++;
      $display("FAIL stall_done got we=%b count=%0d addr=%0d exp 0/1/1", mem_we, count, mem_addr);
    end
  endtask

  task automatic test_illegal();
    do_start();
    mem_ready = 1'b1;
    set_bundle(6, 1, 2, 3, 0, 0, 32'd0);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL illegal_ready got %b exp 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    vectors++;
    if (mem_we !== 1'b0 || err !== 1'b1 || mem_addr !== 2'd0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL illegal_drop got we=%b err=%b addr=%0d count=%0d exp 0/1/0/0", mem_we, err, mem_addr, count);
    end
    do_start();
  endtask

  task automatic test_imm_range();
    do_start();
    mem_ready = 1'b1;
    set_bundle(3, 1, 0, 0, 0, 0, 32'd2048);
    tick();
    in_valid = 1'b0;
    vectors++;
`ifdef ENC_IMM_CHECK_EN
    if (mem_we !== 1'b0 || err !== 1'b1) begin
      miscompares++; $display("FAIL imm_range got we=%b err=%b exp 0/1", mem_we, err);
    end
`else
    if (mem_we !== 1'b1 || mem_wdata !== 32'h80000093 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL imm_trunc got we=%b data=%h err=%b exp 1/80000093/0", mem_we, mem_wdata, err);
    end
`endif
    tick();
  endtask

  task automatic test_full();
    do_start();
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_bundle(3, i + 1, 0, 0, 0, 0, 32'(i));
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++; $display("FAIL fill_ready[%0d] got %b exp 1", i, in_ready);
      end
      tick();
    end
    #1;
    vectors++;
    if (in_ready !== 1'b0 || mem_addr !== 2'd3 || mem_we !== 1'b1) begin
      miscompares++;
      $display("FAIL last_ready got ready=%b addr=%0d we=%b exp 0/3/1", in_ready, mem_addr, mem_we);
    end
    tick();
    vectors++;
    if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4 || mem_we !== 1'b0 || mem_addr !== 2'd3) begin
      miscompares++;
      $display("FAIL full_state got full=%b ready=%b count=%0d we=%b addr=%0d exp 1/0/4/0/3",
               full, in_ready, count, mem_we, mem_addr);
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (full !== 1'b1 || count !== 3'd4) begin
      miscompares++; $display("FAIL full_hold got full=%b count=%0d exp 1/4", full, count);
    end
    do_start();
  endtask

  task automatic test_random();
    wr_t         q[$];
    wr_t         e;
    int          pushed;
    bit          exp_err;
    bit          done;
    int          r;
    int          cls;
    logic [31:0] imm_v;
    for (int ep = 0; ep < 10; ep++) begin
      do_start();
      q.delete();
      pushed  = 0;
      exp_err = 1'b0;
      done    = 1'b0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
        r     = int'($urandom_range(0, 15));
        cls   = (r < 13) ? (r % 5) : (5 + r - 13);
        imm_v = ($urandom_range(0, 1) != 0) ? $urandom : (32'($urandom_range(0, 8191)) - 32'd4096);
        set_bundle(cls, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 127)), imm_v);
        in_valid  = ($urandom_range(0, 3) != 0);
        mem_ready = ($urandom_range(0, 2) != 0);
        #1;
        if (mem_we && mem_ready) begin
          vectors++;
          if (q.size() == 0) begin
            miscompares++;
            $display("FAIL rand_spurious got addr=%0d data=%h exp no write", mem_addr, mem_wdata);
          end else begin
            e = q.pop_front();
            if (mem_addr !== e.a || mem_wdata !== e.d) begin
              miscompares++;
              $display("FAIL rand_write got addr=%0d data=%h exp addr=%0d data=%h",
                       mem_addr, mem_wdata, e.a, e.d);
            end
          end
        end
        if (in_valid && in_ready) begin
          if (ref_legal(cls, imm_v)) begin
            e.a = AW'(pushed);
            e.d = ref_word(cls, 32'(in_rd), 32'(in_rs1), 32'(in_rs2),
                           32'(in_funct3), 32'(in_funct7), imm_v);
            q.push_back(e);
            pushed++;
          end else begin
            exp_err = 1'b1;
          end
        end
        tick();
        done = (pushed == 4) && (q.size() == 0);
      end
      in_valid = 1'b0;
      vectors++;
      if (!done) begin
        miscompares++;
        $display("FAIL rand_timeout got pushed=%0d pending=%0d exp 4/0", pushed, q.size());
      end
      vectors++;
      if (full !== 1'b1 || count !== 3'd4 || err !== exp_err || mem_we !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_end got full=%b count=%0d err=%b we=%b exp 1/4/%b/0",
                 full, count, err, mem_we, exp_err);
      end
    end
  endtask

  task automatic test_reset_midwrite();
    do_start();
    mem_ready = 1'b1;
    set_bundle(0, 2, 3, 0, 2, 0, 32'd16);
    tick();
    set_bundle(3, 4, 5, 0, 0, 0, 32'd7);
    tick();
    in_valid  = 1'b0;
    mem_ready = 1'b0;
    vectors++;
    if (mem_we !== 1'b1 || count !== 3'd1) begin
      miscompares++; $display("FAIL midwrite_pending got we=%b count=%0d exp 1/1", mem_we, count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_we !== 1'b0 || count !== '0 || mem_addr !== '0 || mem_wdata !== 32'h0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL midwrite_reset got we=%b count=%0d addr=%0d data=%h err=%b exp 0/0/0/0/0",
               mem_we, count, mem_addr, mem_wdata, err);
    end
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (mem_we !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL midwrite_after got we=%b ready=%b exp 0/1", mem_we, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_itype();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_imm_range();
    test_full();
    test_random();
    test_reset_midwrite();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
